yz_buyruk_sirali: RTL

- Sequencer directly upstream of yapay_zeka_hizlandiricisi.
- Accepts decoded X-type AI instructions from the execute stage via a valid/ready handshake.
- Converts each instruction into single-cycle command pulses on the accelerator's load_w/load_x/clr_w/clr_x/run inputs; dual-operand loads are split into two beats.
- Waits a fixed latency after run, then returns the result and exception status to the pipeline.

---
 rtl/yz_buyruk_sirali_pkg.sv | 30 +++
 rtl/yz_buyruk_sirali_doluluk_sayaci.sv | 26 ++
 rtl/yz_buyruk_sirali.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/yz_buyruk_sirali_pkg.sv
// Shared opcodes, FSM state encodings and the latched-instruction record for the
// AI accelerator sequencer.
package yz_buyruk_sirali_pkg;

    localparam logic [2:0] YZ_OP_NOP   = 3'd0;
    localparam logic [2:0] YZ_OP_LOADW = 3'd1;
    localparam logic [2:0] YZ_OP_LOADX = 3'd2;
    localparam logic [2:0] YZ_OP_CLRW  = 3'd3;
    localparam logic [2:0] YZ_OP_CLRX  = 3'd4;
    localparam logic [2:0] YZ_OP_RUN   = 3'd5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BEAT1    = 3'd1;
    localparam logic [2:0] ST_BEAT2    = 3'd2;
    localparam logic [2:0] ST_RUN_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_AUTOCLR  = 3'd5;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        rs2_en;
    } yz_instr_t;

    function automatic logic yz_is_load(input logic [2:0] op);
        return (op == YZ_OP_LOADW) || (op == YZ_OP_LOADX);
    endfunction

endpackage

// File: rtl/yz_buyruk_sirali_doluluk_sayaci.sv
// Saturating occupancy counter for one accelerator buffer; clear wins over increment.
module yz_doluluk_sayaci #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_full)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/yz_buyruk_sirali.sv
// Sequencer that turns decoded X-type AI instructions into single-cycle accelerator
// command pulses. Optional macro YZ_OTO_TEMIZLE_EN: joint buffer clear after a clean run.
module yz_buyruk_sirali
    import yz_buyruk_sirali_pkg::*;
#(
    parameter int RUN_LATENCY = 2,
    parameter int DEPTH       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        in_rs2_en,
    output logic [31:0] acc_src_reg1_val,
    output logic        acc_rs2_enable,
    output logic        acc_load_w,
    output logic        acc_load_x,
    output logic        acc_clr_w,
    output logic        acc_clr_x,
    output logic        acc_run,
    input  logic        acc_w_full,
    input  logic        acc_x_full,
    input  logic [31:0] acc_dst_reg_val,
    input  logic        acc_exception,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        out_exc,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(RUN_LATENCY + 1);

    logic [2:0]    r_state;
    yz_instr_t     r_ins;
    logic          r_exc;
    logic [31:0]   r_result;
    logic          r_out_valid;
    logic          r_load_w, r_load_x, r_clr_w, r_clr_x, r_run;
    logic [31:0]   r_src;
    logic [RW-1:0] r_wait;

    logic [CW-1:0] w_w_cnt, w_x_cnt;
    logic          w_w_full, w_x_full, w_w_empty, w_x_empty;
    logic          w_is_w, w_tgt_full, w_beat, w_w_inc, w_x_inc, w_w_clr, w_x_clr;
    logic          w_cnt_mismatch;

    assign w_is_w     = (r_ins.op == YZ_OP_LOADW);
    // Local counter and the accelerator's own flag both block a load.
    assign w_tgt_full = w_is_w ? (w_w_full | acc_w_full) : (w_x_full | acc_x_full);
    assign w_beat     = ((r_state == ST_BEAT1) || (r_state == ST_BEAT2)) && yz_is_load(r_ins.op);
    assign w_w_inc    = w_beat && w_is_w && !w_tgt_full;
    assign w_x_inc    = w_beat && !w_is_w && !w_tgt_full;
`ifdef YZ_OTO_TEMIZLE_EN
    assign w_w_clr    = ((r_state == ST_BEAT1) && (r_ins.op == YZ_OP_CLRW)) || (r_state == ST_AUTOCLR);
    assign w_x_clr    = ((r_state == ST_BEAT1) && (r_ins.op == YZ_OP_CLRX)) || (r_state == ST_AUTOCLR);
`else
    assign w_w_clr    = (r_state == ST_BEAT1) && (r_ins.op == YZ_OP_CLRW);
    assign w_x_clr    = (r_state == ST_BEAT1) && (r_ins.op == YZ_OP_CLRX);
`endif
    assign w_cnt_mismatch = (w_w_empty != w_x_empty) || (w_w_cnt != w_x_cnt);

    yz_doluluk_sayaci #(.DEPTH(DEPTH), .CW(CW)) u_w_sayac (
        .clk(clk), .rst(rst), .i_inc(w_w_inc), .i_clr(w_w_clr),
        .o_cnt(w_w_cnt), .o_full(w_w_full), .o_empty(w_w_empty)
    );

    yz_doluluk_sayaci #(.DEPTH(DEPTH), .CW(CW)) u_x_sayac (
        .clk(clk), .rst(rst), .i_inc(w_x_inc), .i_clr(w_x_clr),
        .o_cnt(w_x_cnt), .o_full(w_x_full), .o_empty(w_x_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ins       <= '0;
            r_exc       <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_load_w    <= 1'b0;
            r_load_x    <= 1'b0;
            r_clr_w     <= 1'b0;
            r_clr_x     <= 1'b0;
            r_run       <= 1'b0;
            r_src       <= '0;
            r_wait      <= '0;
        end else begin
            r_load_w    <= 1'b0;
            r_load_x    <= 1'b0;
            r_clr_w     <= 1'b0;
            r_clr_x     <= 1'b0;
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_ins    <= '{op: in_op, rs1: in_rs1, rs2: in_rs2, rs2_en: in_rs2_en};
                    r_exc    <= 1'b0;
                    r_result <= '0;
                    case (in_op)
                        YZ_OP_LOADW, YZ_OP_LOADX, YZ_OP_CLRW, YZ_OP_CLRX, YZ_OP_RUN:
                            r_state <= ST_BEAT1;
                        default: begin
                            r_exc   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    endcase
                end
                ST_BEAT1: case (r_ins.op)
                    YZ_OP_CLRW: begin
                        r_clr_w <= 1'b1;
                        r_state <= ST_DONE;
                    end
                    YZ_OP_CLRX: begin
                        r_clr_x <= 1'b1;
                        r_state <= ST_DONE;
                    end
                    YZ_OP_RUN: begin
                        r_run   <= 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_RUN_WAIT;
                    end
                    YZ_OP_LOADW, YZ_OP_LOADX: begin
                        if (w_tgt_full)
                            r_exc <= 1'b1;
                        else begin
                            r_load_w <= w_is_w;
                            r_load_x <= !w_is_w;
                            r_src    <= r_ins.rs1;
                        end
                        r_state <= r_ins.rs2_en ? ST_BEAT2 : ST_DONE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
                ST_BEAT2: begin
                    if (w_tgt_full)
                        r_exc <= 1'b1;
                    else begin
                        r_load_w <= w_is_w;
                        r_load_x <= !w_is_w;
                        r_src    <= r_ins.rs2;
                    end
                    r_state <= ST_DONE;
                end
                ST_RUN_WAIT: begin
                    if (r_wait == RW'(RUN_LATENCY - 1)) begin
                        r_result <= acc_dst_reg_val;
                        r_exc    <= w_cnt_mismatch | acc_exception;
                        r_state  <= ST_DONE;
                    end else
                        r_wait <= r_wait + 1'b1;
                end
                ST_DONE: begin
                    r_out_valid <= 1'b1;
`ifdef YZ_OTO_TEMIZLE_EN
                    r_state     <= ((r_ins.op == YZ_OP_RUN) && !r_exc) ? ST_AUTOCLR : ST_IDLE;
`else
                    r_state     <= ST_IDLE;
`endif
                end
`ifdef YZ_OTO_TEMIZLE_EN
                ST_AUTOCLR: begin
                    r_clr_w <= 1'b1;
                    r_clr_x <= 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready         = (r_state == ST_IDLE);
    assign busy             = !in_ready;
    assign acc_src_reg1_val = r_src;
    assign acc_rs2_enable   = 1'b0;
    assign acc_load_w       = r_load_w;
    assign acc_load_x       = r_load_x;
    assign acc_clr_w        = r_clr_w;
    assign acc_clr_x        = r_clr_x;
    assign acc_run          = r_run;
    assign out_valid        = r_out_valid;
    assign out_result       = r_result;
    assign out_exc          = r_exc;
endmodule
